// File: rtl/sinepwm_multi.sv
// sinepwm_multi: DDS phase accumulator driving PHASES phase-shifted, amplitude-scaled sine PWM outputs.
// Latency: pwm_out is registered 1 clk behind the carrier counter; host inputs act at the next carrier period start.
// Backpressure: none; free-running on the prescaler tick, inputs sampled once per carrier period (glitch-free).
module sinepwm_multi #(
    parameter int PHASES   = 3,
    parameter int PWM_BITS = 8,
    parameter int TBL_BITS = 5,
    parameter int ACC_BITS = 32,
    parameter int DIVIDER  = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic signed [31:0]  freq,
    input  logic [PWM_BITS-1:0] amplitude,
    output logic                en,
    output logic [PHASES-1:0]   pwm_out,
    output logic                sync
);
    localparam int TBL_SIZE  = 1 << TBL_BITS;
    localparam int SHIFT     = ACC_BITS - TBL_BITS;
    localparam int PRE_BITS  = (DIVIDER > 0) ? $clog2(DIVIDER + 1) : 1;
    localparam int PROD_BITS = 2 * PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] MID      = PWM_BITS'(1 << (PWM_BITS - 1));
    localparam logic [ACC_BITS-1:0] OFS      = ACC_BITS'((65'd1 << ACC_BITS) / PHASES);

    // Rounded sine sample scaled to +/-(2^(PWM_BITS-1)-1); evaluated at elaboration only
    function automatic logic signed [PWM_BITS-1:0] sin_entry(input int i);
        real v;
        int  r;
        v = $sin(2.0 * 3.14159265358979323846 * real'(i) / real'(TBL_SIZE))
            * real'((1 << (PWM_BITS - 1)) - 1);
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return PWM_BITS'(r);
    endfunction

    logic [PRE_BITS-1:0]        presc;
    logic [PWM_BITS-1:0]        pwm_cnt;
    logic [ACC_BITS-1:0]        acc;
    logic [PWM_BITS-1:0]        duty [PHASES];
    logic                       run;
    logic                       tick;
    logic                       period_start;
    logic [ACC_BITS-1:0]        finc;
    logic [ACC_BITS:0]          acc_sum;
    logic [ACC_BITS-1:0]        acc_nxt;
    logic                       wrap;
    logic [PWM_BITS-1:0]        duty_nxt [PHASES];
    logic signed [PWM_BITS-1:0] sin_tbl [TBL_SIZE];

    for (genvar i = 0; i < TBL_SIZE; i++) begin : g_tbl
        assign sin_tbl[i] = sin_entry(i);
    end

    assign tick         = (presc == '0);
    assign period_start = tick && (pwm_cnt == CNT_LAST);

    // Signed increment: the carry bit of the widened sum is a wrap for forward rotation,
    // and its absence is a borrow (wrap) for reverse rotation.
    assign finc    = ACC_BITS'(freq);
    assign acc_sum = {1'b0, acc} + {1'b0, finc};
    assign acc_nxt = acc_sum[ACC_BITS-1:0];
    assign wrap    = (finc != '0) && (finc[ACC_BITS-1] ? ~acc_sum[ACC_BITS] : acc_sum[ACC_BITS]);

    // Per-channel table lookup at the phase-shifted accumulator and amplitude scaling
    for (genvar k = 0; k < PHASES; k++) begin : g_ch
        localparam logic [ACC_BITS-1:0] CH_OFS = ACC_BITS'(k) * OFS;
        logic [TBL_BITS-1:0]         idx;
        logic signed [PROD_BITS-1:0] prod;
        assign idx  = TBL_BITS'((acc_nxt + CH_OFS) >> SHIFT);
        assign prod = PROD_BITS'(sin_tbl[idx]) * PROD_BITS'($signed({1'b0, amplitude}));
        assign duty_nxt[k] = MID + PWM_BITS'(prod >>> PWM_BITS);
    end

    // Prescaler: down counter that pulses tick at zero and reloads DIVIDER
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= PRE_BITS'(DIVIDER);
        else           presc <= presc - PRE_BITS'(1);
    end

    // Carrier counter: 0 .. 2^PWM_BITS-2 per tick, wrap marks the period start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               pwm_cnt <= '0;
        else if (period_start) pwm_cnt <= '0;
        else if (tick)         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    // Period-start update: sample enable, advance phase, load duties, flag phase wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            run  <= 1'b0;
            sync <= 1'b0;
            for (int k = 0; k < PHASES; k++) duty[k] <= '0;
        end else begin
            sync <= 1'b0;
            if (period_start) begin
                run <= enable;
                if (enable) begin
                    acc  <= acc_nxt;
                    sync <= wrap;
                    for (int k = 0; k < PHASES; k++) duty[k] <= duty_nxt[k];
                end else begin
                    for (int k = 0; k < PHASES; k++) duty[k] <= '0;
                end
            end
        end
    end

    // Comparator outputs, registered so pins never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            for (int k = 0; k < PHASES; k++) pwm_out[k] <= run && (pwm_cnt < duty[k]);
        end
    end

    // Driver enable pin follows the host enable every clk, independent of the carrier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) en <= 1'b0;
        else     en <= enable;
    end
endmodule

// File: tb/tb_sinepwm_multi.sv
module tb_sinepwm_multi;
    localparam longint TWO32 = 64'sd4294967296;
    localparam longint OFS   = TWO32 / 3;
    localparam int     PER   = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic signed [31:0] freq = '0;
    logic [7:0]        amplitude = '0;
    logic              en, sync, en3, sync3;
    logic [2:0]        pwm_out, pwm3;

    always #5 clk = ~clk;

    sinepwm_multi #(.PHASES(3), .PWM_BITS(8), .TBL_BITS(5), .ACC_BITS(32), .DIVIDER(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .freq(freq), .amplitude(amplitude),
        .en(en), .pwm_out(pwm_out), .sync(sync));

    sinepwm_multi #(.PHASES(3), .PWM_BITS(8), .TBL_BITS(5), .ACC_BITS(32), .DIVIDER(3)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .freq(freq), .amplitude(amplitude),
        .en(en3), .pwm_out(pwm3), .sync(sync3));

    typedef struct {
        logic signed [31:0] f;
        int amp;
        bit ena;
        int periods;
        int d0, d1, d2;
        int syncs;
    } vec_t;

    vec_t   vecs[6];
    int     checks = 0;
    int     passed = 0;
    int     tbl[32];
    longint m_acc;
    int     obs_duty[3];
    int     hi[3];
    int     last_hi[3];
    int     cyc;
    int     sync_cnt;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    // duty = 128 + floor(sin_sample * amplitude / 256) at the channel's table position
    function automatic int duty_of(input longint acc, input int k, input int a);
        int idx;
        idx = int'(((acc + k * OFS) % TWO32) / (TWO32 / 32));
        return 128 + $rtoi($floor(real'(tbl[idx] * a) / 256.0));
    endfunction

    task automatic model_reset();
        m_acc = 0;
        cyc = 0;
        sync_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            obs_duty[k] = 0;
            hi[k] = 0;
            last_hi[k] = 0;
        end
    endtask

    // One clk: model the period start from the inputs present at the edge, then check outputs
    task automatic cycle();
        bit     in_en;
        bit     exp_sync;
        longint f;
        longint t;
        int     a;
        int     nd[3];
        in_en = enable;
        f = longint'(freq);
        a = int'(amplitude);
        exp_sync = 1'b0;
        nd = '{0, 0, 0};
        @(posedge clk);
        cyc++;
        if ((cyc % PER == 0) && in_en) begin
            t = m_acc + f;
            exp_sync = (t < 0) || (t >= TWO32);
            if (t < 0) t += TWO32;
            else if (t >= TWO32) t -= TWO32;
            m_acc = t;
            for (int k = 0; k < 3; k++) nd[k] = duty_of(m_acc, k, a);
        end
        #1;
        check("en", en, in_en);
        check("sync", sync, exp_sync);
        if (sync) sync_cnt++;
        for (int k = 0; k < 3; k++) hi[k] += int'(pwm_out[k]);
        if (cyc % PER == 0) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("high_ticks_ch%0d", k), hi[k], obs_duty[k]);
                last_hi[k] = hi[k];
                hi[k] = 0;
                obs_duty[k] = nd[k];
            end
        end
    endtask

    task automatic assert_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_pwm"}, pwm_out, 0);
        check({tag, "_en"}, en, 0);
        check({tag, "_sync"}, sync, 0);
        check({tag, "_pwm_div3"}, pwm3, 0);
        check({tag, "_sync_div3"}, sync3, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int s0;
        int r1, r2, fall;
        bit prev;
        for (int i = 0; i < 32; i++) tbl[i] = rnd(127.0 * $sin(2.0 * 3.14159265358979323846 * i / 32.0));

        vecs[0] = '{32'sh0800_0000, 255, 1'b1, 1, 152, 233, 11, 0};
        vecs[1] = '{32'sh0800_0000, 255, 1'b1, 8, 254, 79, 57, 0};
        vecs[2] = '{32'shF800_0000, 255, 1'b1, 1, 103, 252, 38, 1};
        vecs[3] = '{32'sh0800_0000, 0,   1'b1, 3, 128, 128, 128, 0};
        vecs[4] = '{32'sh0800_0000, 255, 1'b0, 2, 0, 0, 0, 0};
        vecs[5] = '{32'sh8000_0000, 255, 1'b1, 1, 128, 11, 233, 1};

        // Table-driven vectors: fresh reset, fixed inputs, check the last observed period
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            assert_reset("reset");
            freq = vecs[v].f;
            amplitude = 8'(vecs[v].amp);
            enable = vecs[v].ena;
            repeat (vecs[v].periods * PER) cycle();
            s0 = sync_cnt;
            repeat (PER) cycle();
            check($sformatf("vec%0d_ch0", v), last_hi[0], vecs[v].d0);
            check($sformatf("vec%0d_ch1", v), last_hi[1], vecs[v].d1);
            check($sformatf("vec%0d_ch2", v), last_hi[2], vecs[v].d2);
            check($sformatf("vec%0d_syncs", v), s0, vecs[v].syncs);
        end

        // Reverse rotation: one borrow pulse per 32 periods
        @(negedge clk);
        assert_reset("reset");
        freq = 32'shF800_0000;
        amplitude = 8'd255;
        enable = 1'b1;
        repeat (65 * PER) cycle();
        check("reverse_sync_count", sync_cnt, 3);

        // Reset mid-period while running; first duty only after a full carrier period
        @(negedge clk);
        assert_reset("reset");
        freq = 32'sh0800_0000;
        amplitude = 8'd255;
        enable = 1'b1;
        repeat (2 * PER + 60) cycle();
        check("pre_reset_active", (pwm_out != 3'b000), 1);
        #2;
        assert_reset("reset_mid");
        repeat (PER) cycle();
        check("post_reset_first_period_ch0", last_hi[0], 0);
        repeat (PER) cycle();
        check("post_reset_second_period_ch0", last_hi[0], 152);
        check("post_reset_second_period_ch1", last_hi[1], 233);
        check("post_reset_second_period_ch2", last_hi[2], 11);

        // Hold phase with freq=0, drop enable mid-period, then re-enable
        @(negedge clk);
        assert_reset("reset");
        freq = 32'sh0800_0000;
        amplitude = 8'd200;
        enable = 1'b1;
        repeat (3 * PER) cycle();
        freq = '0;
        repeat (PER + 100) cycle();
        enable = 1'b0;
        cycle();
        check("en_falls_after_1clk", en, 0);
        repeat (PER - 101) cycle();
        check("disable_period_completes_ch0", last_hi[0], duty_of(longint'(3) * 134217728, 0, 200));
        repeat (PER) cycle();
        check("disabled_period_ch0", last_hi[0], 0);
        enable = 1'b1;
        repeat (2 * PER) cycle();
        check("reenable_acc_held_ch1", last_hi[1], duty_of(longint'(3) * 134217728, 1, 200));

        // Randomized inputs changed at random points within each period
        @(negedge clk);
        assert_reset("reset");
        for (int p = 0; p < 40; p++) begin
            int off;
            off = $urandom_range(0, PER - 1);
            for (int i = 0; i < PER; i++) begin
                if (i == off) begin
                    case ($urandom_range(0, 3))
                        0: freq = 32'($urandom);
                        1: freq = 32'($urandom_range(0, 32'h1000_0000)) - 32'sh0800_0000;
                        2: freq = '0;
                        default: freq = ($urandom_range(0, 1) != 0) ? 32'sh8000_0000 : 32'sh3000_0000;
                    endcase
                    amplitude = 8'($urandom_range(0, 255));
                    enable = ($urandom_range(0, 4) != 0);
                end
                cycle();
            end
        end

        // Prescaler DIVIDER=3: carrier period 1020 clk, 50 % duty at amplitude 0
        @(negedge clk);
        assert_reset("reset");
        freq = 32'sh0800_0000;
        amplitude = 8'd0;
        enable = 1'b1;
        r1 = -1;
        r2 = -1;
        fall = -1;
        prev = 1'b0;
        for (int i = 0; i < 6000 && r2 < 0; i++) begin
            cycle();
            if (pwm3[0] && !prev) begin
                if (r1 < 0) r1 = cyc;
                else r2 = cyc;
            end
            if (!pwm3[0] && prev && r1 >= 0 && fall < 0) fall = cyc;
            prev = pwm3[0];
        end
        check("div3_found_two_periods", (r2 >= 0), 1);
        check("div3_carrier_period_clk", r2 - r1, 1020);
        check("div3_high_time_clk", fall - r1, 512);
        check("div3_en", en3, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
